// File: rtl/sdram_ram_arb.sv
// sdram_ram_arb: two-master arbiter for the SDRAM word RAM port.
// Macro SDRAM_ARB_FIXED_PRIO_EN: requester 0 always wins ties.
module sdram_ram_arb #(
  parameter int MAX_PENDING = 4
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [31:0] req0_addr_i,
  input  logic [3:0]  req0_wr_i,
  input  logic        req0_rd_i,
  input  logic [7:0]  req0_len_i,
  input  logic [31:0] req0_write_data_i,
  output logic        req0_accept_o,
  output logic        req0_ack_o,
  output logic        req0_error_o,
  output logic [31:0] req0_read_data_o,
  input  logic [31:0] req1_addr_i,
  input  logic [3:0]  req1_wr_i,
  input  logic        req1_rd_i,
  input  logic [7:0]  req1_len_i,
  input  logic [31:0] req1_write_data_i,
  output logic        req1_accept_o,
  output logic        req1_ack_o,
  output logic        req1_error_o,
  output logic [31:0] req1_read_data_o,
  output logic [31:0] ram_addr_o,
  output logic [3:0]  ram_wr_o,
  output logic        ram_rd_o,
  output logic [7:0]  ram_len_o,
  output logic [31:0] ram_write_data_o,
  input  logic        ram_accept_i,
  input  logic        ram_ack_i,
  input  logic        ram_error_i,
  input  logic [31:0] ram_read_data_i
);

  localparam int PW = $clog2(MAX_PENDING);
  localparam int CW = PW + 1;

  logic             r_gnt;
  logic             r_busy;
  logic [7:0]       r_lock_cnt;
  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;
  logic [CW-1:0]    r_cnt;
  logic [MAX_PENDING-1:0] r_own;

  logic       w_req0;
  logic       w_req1;
  logic       w_hold;
  logic       w_tie;
  logic       w_gnt;
  logic       w_valid;
  logic       w_sel;
  logic       w_full;
  logic       w_empty;
  logic       w_acc;
  logic       w_pop;
  logic       w_head;
  logic [7:0] w_len;

  assign w_req0 = req0_rd_i | (|req0_wr_i);
  assign w_req1 = req1_rd_i | (|req1_wr_i);
  assign w_hold = r_busy | (r_lock_cnt != 8'd0);

`ifdef SDRAM_ARB_FIXED_PRIO_EN
  assign w_tie = 1'b0;
`else
  logic r_last;
  logic w_last_upd;

  // a request ends on a single-beat accept or its final burst beat
  assign w_last_upd = w_acc & ((r_lock_cnt == 8'd0) ?
                               (w_len == 8'd0) :
                               (r_lock_cnt == 8'd1));
  assign w_tie = ~r_last;

  // remember the last owner so the other side wins the next tie
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_last <= 1'b1;
    end else if (w_last_upd) begin
      r_last <= w_gnt;
    end
  end
`endif

  // pick the owner: hold while presenting or bursting, else arbitrate
  always_comb begin
    w_gnt = r_gnt;
    if (!w_hold) begin
      if (w_req0 & w_req1) begin
        w_gnt = w_tie;
      end else begin
        w_gnt = w_req1;
      end
    end
  end

  assign w_valid = w_gnt ? w_req1 : w_req0;
  assign w_sel   = w_valid & w_gnt;
  assign w_full  = (r_cnt == CW'(MAX_PENDING));
  assign w_empty = (r_cnt == '0);
  assign w_acc   = ram_accept_i & w_valid & ~w_full;
  assign w_pop   = ram_ack_i & ~w_empty;
  assign w_head  = r_own[r_rptr];
  assign w_len   = w_sel ? req1_len_i : req0_len_i;

  assign ram_addr_o       = w_sel ? req1_addr_i : req0_addr_i;
  assign ram_len_o        = w_len;
  assign ram_write_data_o = w_sel ? req1_write_data_i
                                  : req0_write_data_i;
  assign ram_wr_o = (w_valid & ~w_full) ?
                    (w_sel ? req1_wr_i : req0_wr_i) : 4'd0;
  assign ram_rd_o = w_valid & ~w_full &
                    (w_sel ? req1_rd_i : req0_rd_i);

  assign req0_accept_o    = w_acc & ~w_gnt;
  assign req1_accept_o    = w_acc & w_gnt;
  assign req0_ack_o       = w_pop & ~w_head;
  assign req1_ack_o       = w_pop & w_head;
  assign req0_error_o     = ram_error_i & req0_ack_o;
  assign req1_error_o     = ram_error_i & req1_ack_o;
  assign req0_read_data_o = ram_read_data_i;
  assign req1_read_data_o = ram_read_data_i;

  // grant hold, presented-but-unaccepted flag and burst counter
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_gnt      <= 1'b0;
      r_busy     <= 1'b0;
      r_lock_cnt <= 8'd0;
    end else begin
      r_gnt  <= w_gnt;
      r_busy <= w_valid & ~w_acc;
      if (w_acc) begin
        if (r_lock_cnt == 8'd0) begin
          r_lock_cnt <= w_len;
        end else begin
          r_lock_cnt <= r_lock_cnt - 8'd1;
        end
      end
    end
  end

  // owner FIFO pointers and occupancy
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_acc) begin
        r_wptr <= r_wptr + PW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PW'(1);
      end
      if (w_acc & ~w_pop) begin
        r_cnt <= r_cnt + CW'(1);
      end else if (~w_acc & w_pop) begin
        r_cnt <= r_cnt - CW'(1);
      end
    end
  end

  // owner FIFO storage, one id bit per accepted beat
  always_ff @(posedge clk_i) begin
    if (w_acc) begin
      r_own[r_wptr] <= w_gnt;
    end
  end

endmodule

// File: tb/tb_sdram_ram_arb.sv
// tb_sdram_ram_arb: directed vector bench for sdram_ram_arb.
// Default build (round-robin) expectations.
module tb_sdram_ram_arb;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] a0 = '0, a1 = '0, wd0 = '0, wd1 = '0;
  logic [3:0]  w0 = '0, w1 = '0;
  logic        r0 = 1'b0, r1 = 1'b0;
  logic [7:0]  l0 = '0, l1 = '0;
  logic        acc0, ack0, err0, acc1, ack1, err1;
  logic [31:0] rd0, rd1;
  logic [31:0] ram_addr, ram_wd;
  logic [3:0]  ram_wr;
  logic        ram_rd;
  logic [7:0]  ram_len;
  logic        ram_acc = 1'b0, ram_ack = 1'b0, ram_err = 1'b0;
  logic [31:0] ram_rdata = '0;

  always #5 clk = ~clk;

  sdram_ram_arb #(.MAX_PENDING(4)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .req0_addr_i(a0), .req0_wr_i(w0), .req0_rd_i(r0),
    .req0_len_i(l0), .req0_write_data_i(wd0),
    .req0_accept_o(acc0), .req0_ack_o(ack0),
    .req0_error_o(err0), .req0_read_data_o(rd0),
    .req1_addr_i(a1), .req1_wr_i(w1), .req1_rd_i(r1),
    .req1_len_i(l1), .req1_write_data_i(wd1),
    .req1_accept_o(acc1), .req1_ack_o(ack1),
    .req1_error_o(err1), .req1_read_data_o(rd1),
    .ram_addr_o(ram_addr), .ram_wr_o(ram_wr),
    .ram_rd_o(ram_rd), .ram_len_o(ram_len),
    .ram_write_data_o(ram_wd),
    .ram_accept_i(ram_acc), .ram_ack_i(ram_ack),
    .ram_error_i(ram_err), .ram_read_data_i(ram_rdata)
  );

  typedef struct {
    logic        r0;
    logic [3:0]  w0;
    logic [7:0]  l0;
    logic [31:0] a0;
    logic        r1;
    logic [3:0]  w1;
    logic [7:0]  l1;
    logic        acc;
    logic        ack;
    logic        err;
    logic [6:0]  exp;
  } vec_t;

  vec_t tbl[$];
  int n_cmp = 0;
  int n_bad = 0;

  function automatic vec_t mk(
    logic r_0, logic [3:0] w_0, logic [7:0] l_0,
    logic [31:0] a_0, logic r_1, logic [3:0] w_1,
    logic [7:0] l_1, logic ac, logic ak, logic er,
    logic [6:0] e);
    vec_t v;
    v.r0 = r_0; v.w0 = w_0; v.l0 = l_0; v.a0 = a_0;
    v.r1 = r_1; v.w1 = w_1; v.l1 = l_1;
    v.acc = ac; v.ack = ak; v.err = er; v.exp = e;
    return v;
  endfunction

  task automatic drive(vec_t v, int idx);
    r0 = v.r0; w0 = v.w0; l0 = v.l0; a0 = v.a0;
    r1 = v.r1; w1 = v.w1; l1 = v.l1;
    a1 = v.a0 + 32'h1000;
    wd0 = ~v.a0;
    wd1 = v.a0 ^ 32'h5555_5555;
    ram_acc = v.acc; ram_ack = v.ack; ram_err = v.err;
    ram_rdata = 32'hD000_0000 + 32'(idx);
  endtask

  function automatic logic [6:0] obs();
    return {acc0, acc1, ack0, ack1, err0, err1,
            ram_rd | (|ram_wr)};
  endfunction

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // step one cycle: drive after negedge, sample 1ns later
  task automatic step(vec_t v, int idx);
    @(negedge clk);
    drive(v, idx);
    #1;
  endtask

  localparam logic [3:0] F = 4'hF;

  initial begin
    vec_t idle;
    int cnt;
    idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 7'b0);

    // alternation: both write every cycle
    tbl.push_back(mk(0, F, 0, 32'h10, 0, F, 0, 1, 0, 0,
                     7'b1000001));
    tbl.push_back(mk(0, F, 0, 32'h14, 0, F, 0, 1, 1, 0,
                     7'b0110001));
    tbl.push_back(mk(0, F, 0, 32'h18, 0, F, 0, 1, 1, 0,
                     7'b1001001));
    tbl.push_back(mk(0, F, 0, 32'h1C, 0, F, 0, 1, 1, 1,
                     7'b0110101));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0,
                     7'b0001000));
    // requester 0 single reads, acked 2 cycles later
    tbl.push_back(mk(1, 0, 0, 32'h100, 0, 0, 0, 1, 0, 0,
                     7'b1000001));
    tbl.push_back(mk(1, 0, 0, 32'h104, 0, 0, 0, 1, 0, 0,
                     7'b1000001));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0,
                     7'b0010000));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0,
                     7'b0010000));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1,
                     7'b0000000));
    // requester 1 burst len 3, requester 0 waits
    tbl.push_back(mk(0, 0, 0, 32'h40, 1, 0, 3, 1, 0, 0,
                     7'b0100001));
    tbl.push_back(mk(1, 0, 0, 32'h40, 1, 0, 3, 1, 1, 0,
                     7'b0101001));
    tbl.push_back(mk(1, 0, 0, 32'h40, 1, 0, 3, 1, 1, 0,
                     7'b0101001));
    tbl.push_back(mk(1, 0, 0, 32'h40, 1, 0, 3, 1, 1, 0,
                     7'b0101001));
    tbl.push_back(mk(1, 0, 0, 32'h40, 1, 0, 3, 1, 1, 0,
                     7'b1001001));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0,
                     7'b0010000));
    // owners 0,1,1,0 then full, then 4 acks, error on 3rd
    tbl.push_back(mk(1, 0, 0, 32'h80, 0, 0, 0, 1, 0, 0,
                     7'b1000001));
    tbl.push_back(mk(0, 0, 0, 32'h84, 1, 0, 0, 1, 0, 0,
                     7'b0100001));
    tbl.push_back(mk(0, 0, 0, 32'h88, 1, 0, 0, 1, 0, 0,
                     7'b0100001));
    tbl.push_back(mk(1, 0, 0, 32'h8C, 0, 0, 0, 1, 0, 0,
                     7'b1000001));
    tbl.push_back(mk(1, 0, 0, 32'h90, 0, 0, 0, 1, 0, 0,
                     7'b0000000));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0,
                     7'b0010000));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0,
                     7'b0001000));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1,
                     7'b0001010));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0,
                     7'b0010000));

    // reset, with a stray ack that must be ignored
    rst_n = 1'b0;
    ram_ack = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_outputs", 32'(obs()), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    ram_ack = 1'b0;
    #1;
    chk("post_reset_idle", 32'(obs()), 32'h0);

    foreach (tbl[i]) begin
      step(tbl[i], i);
      chk($sformatf("vec%0d", i), 32'(obs()), 32'(tbl[i].exp));
      if (tbl[i].exp[6]) begin
        chk($sformatf("vec%0d_addr0", i), ram_addr, tbl[i].a0);
        chk($sformatf("vec%0d_wd0", i), ram_wd, ~tbl[i].a0);
      end
      if (tbl[i].exp[5]) begin
        chk($sformatf("vec%0d_addr1", i), ram_addr,
            tbl[i].a0 + 32'h1000);
      end
      if (tbl[i].exp[4]) begin
        chk($sformatf("vec%0d_rdata0", i), rd0,
            32'hD000_0000 + 32'(i));
      end
      if (tbl[i].exp[3]) begin
        chk($sformatf("vec%0d_rdata1", i), rd1,
            32'hD000_0000 + 32'(i));
      end
    end

    // downstream never acks: exactly 4 accepts then stall
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      step(mk(1, 0, 0, 32'h300, 0, 0, 0, 1, 0, 0, 7'b0), 100);
      if (acc0) cnt++;
    end
    chk("full_accept_count", 32'(cnt), 32'd4);
    chk("full_ram_rd", 32'(ram_rd), 32'd0);
    step(mk(1, 0, 0, 32'h300, 0, 0, 0, 1, 1, 0, 7'b0), 101);
    chk("full_pop_same_cycle", 32'(obs()), 32'b0010000);
    step(mk(1, 0, 0, 32'h300, 0, 0, 0, 1, 0, 0, 7'b0), 102);
    chk("full_freed_accept", 32'(obs()), 32'b1000001);
    chk("full_freed_addr", ram_addr, 32'h300);
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      step(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 7'b0), 103);
      if (ack0) cnt++;
    end
    chk("drain_ack_count", 32'(cnt), 32'd4);

    // reset mid-burst with 2 pending
    step(mk(0, 0, 0, 32'h500, 1, 0, 3, 1, 0, 0, 7'b0), 110);
    chk("burst_beat0", 32'(obs()), 32'b0100001);
    step(mk(0, 0, 0, 32'h500, 1, 0, 3, 1, 0, 0, 7'b0), 111);
    chk("burst_beat1", 32'(obs()), 32'b0100001);
    @(negedge clk);
    drive(idle, 112);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    drive(mk(1, 0, 0, 32'h600, 0, 0, 0, 1, 1, 0, 7'b0), 113);
    #1;
    chk("rst_unlock_no_ack", 32'(obs()), 32'b1000001);
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 7'b0), 114);
    chk("rst_new_entry_ack", 32'(obs()), 32'b0010000);
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 7'b0), 115);
    chk("rst_empty_ack", 32'(obs()), 32'b0000000);

    step(idle, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
